lcd_spi_rx: RTL and testbench
=============================

// Module: lcd_spi_rx
// PURPOSE
//  SPI slave receiver and command decoder for the display end of the serial LCD link.
//  Samples SCLK/SS_N/MOSI in the system clock domain, assembles MSB-first bytes and decodes the stream.
//  Stream content: printable characters, plus the 3-byte clear sequence ESC '[' 'j' (0x1B 0x5B 0x6A).
//  Outputs one-cycle strobes to the character/display logic; also serves as bench model for the LCD controller.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop stages on sclk, ss_n and mosi; legal range 2..3
//  COLS         16  display columns; used only when LCD_RX_CURSOR_EN is defined
// PORTS
//  clk         in   1  system clock; must be at least 8x the SCLK frequency
//  rst_n       in   1  reset, asynchronous, active-low
//  sclk        in   1  SPI clock, asynchronous to clk; mode 0 (CPOL=0, CPHA=0)
//  ss_n        in   1  SPI slave select, active-low, asynchronous
//  mosi        in   1  SPI data in, asynchronous; sampled on synchronized SCLK rising edge
//  char_data   out  7  last received character, bits [6:0] of the byte
//  char_valid  out  1  one-cycle strobe; char_data holds a new character
//  clear       out  1  one-cycle strobe; complete clear sequence received
//  frame_err   out  1  one-cycle strobe; partial byte at SS_N rise, or byte with bit7=1
//  seq_err     out  1  one-cycle strobe; escape sequence broken by an unexpected byte
// BEHAVIOUR
//  Reset (rst_n=0), any cycle, including mid-byte or mid-sequence:
//   - char_data=0; char_valid=clear=frame_err=seq_err=0
//   - bit counter=0, shift register=0, decoder state=IDLE, synchronizers=idle (sclk=0, ss_n=1)
//  Byte assembly:
//   - Edges are detected on synchronized signals only. Input-to-detect latency is SYNC_STAGES+1 clk.
//   - On ss_n falling edge: bit counter cleared.
//   - While ss_n low, on each sclk rising edge: shift_reg <= {shift_reg[6:0], mosi}; counter increments.
//   - On the 8th bit: internal byte_stb for one cycle; counter wraps to 0. Back-to-back bytes in one SS_N frame are legal.
//   - ss_n rising with counter != 0: partial byte discarded, frame_err pulses, decoder state unchanged.
//   - Completed byte with bit7=1: frame_err pulses, byte dropped, decoder state unchanged.
//   - sclk edges while ss_n high are ignored.
//  Decoder FSM, evaluated on byte_stb; all outputs registered, asserted the cycle after byte_stb:
//   IDLE: 0x1B -> ESC, no output; any other byte -> char_data<=byte[6:0], char_valid=1, stay IDLE
//   ESC:  0x5B -> CSI; 0x1B -> seq_err, stay ESC; other byte -> seq_err, emit it as char, -> IDLE
//   CSI:  0x6A -> clear=1, -> IDLE; 0x1B -> seq_err, -> ESC; other byte -> seq_err, emit it as char, -> IDLE
//  Strobe rules:
//   - At most one of char_valid/clear per byte. seq_err may coincide with char_valid.
//   - char_data holds its value between strobes.
//   - ss_n rising does not reset the decoder: a sequence may span SS_N frames.
// CONFIGURATION
//  LCD_RX_CURSOR_EN defined:
//   - adds output cursor_pos, width $clog2(COLS), reset 0
//   - cursor_pos increments in the same cycle as char_valid; wraps COLS-1 -> 0
//   - cursor_pos cleared to 0 in the same cycle as clear
//  LCD_RX_CURSOR_EN undefined: no cursor_pos port and no cursor logic; all other behaviour identical.
// TESTING
//  1. Frame 0x41 -> char_valid 1 cycle, char_data=7'h41; no other strobe.
//  2. Bytes 0x1B,0x5B,0x6A in one frame -> clear exactly once; char_valid never asserted.
//  3. Bytes 0x1B,0x5B,0x6A, each in its own SS_N frame -> clear exactly once.
//  4. Bytes 0x1B,0x5B,0x42 -> seq_err and char_valid together with char_data=7'h42; decoder back in IDLE.
//  5. 5 bits then SS_N high, then full frame 0x30 -> frame_err once, then char_valid with char_data=7'h30.
//  6. Byte 0xC1 -> frame_err, no char_valid.
//  7. rst_n low mid-sequence (after 0x1B, 0x5B), then byte 0x6A -> char_valid with char_data=7'h6A, no clear.
//  8. With LCD_RX_CURSOR_EN, COLS=16: 17 characters -> cursor_pos=1; then clear sequence -> cursor_pos=0.

Source files
------------

// File: rtl/lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// lcd_spi_rx
//   SPI slave receiver and command decoder for the display end of the serial
//   LCD link. SCLK, SS_N and MOSI are resynchronised into the clk domain. Bytes
//   are assembled MSB first, and the resulting stream is decoded into printable
//   characters and the 3-byte clear sequence ESC '[' 'j' (0x1B 0x5B 0x6A).
//   Every output is a registered strobe that goes to the character/display
//   logic.
//
// Parameters
//   SYNC_STAGES  flip-flop stages on sclk, ss_n and mosi (2..3)
//   COLS         display columns; used only by the cursor option
//
// Ports
//   clk         system clock; must run at least 8x the SCLK frequency
//   rst_n       asynchronous active-low reset
//   sclk        SPI clock, mode 0, asynchronous to clk
//   ss_n        SPI slave select, active-low, asynchronous
//   mosi        SPI data in, asynchronous
//   char_data   last received character (byte bits [6:0]); holds between strobes
//   char_valid  one-cycle strobe: char_data carries a new character
//   clear       one-cycle strobe: complete clear sequence received
//   frame_err   one-cycle strobe: partial byte at SS_N rise, or byte with bit7=1
//   seq_err     one-cycle strobe: escape sequence broken by an unexpected byte
//   cursor_pos  (LCD_RX_CURSOR_EN only) column of the next character
//
// Configuration
//   LCD_RX_CURSOR_EN  when defined, adds the cursor_pos output. The cursor
//                     advances with every char_valid, wraps from COLS-1 to 0,
//                     and is cleared together with clear.
// -----------------------------------------------------------------------------
module lcd_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic [6:0] char_data,
    output logic       char_valid,
    output logic       clear,
    output logic       frame_err,
    output logic       seq_err
`ifdef LCD_RX_CURSOR_EN
    ,
    output logic [$clog2(COLS)-1:0] cursor_pos
`endif
);

    localparam logic [7:0] ESC_BYTE   = 8'h1B;
    localparam logic [7:0] CSI_BYTE   = 8'h5B;
    localparam logic [7:0] CLEAR_BYTE = 8'h6A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ESC,
        ST_CSI
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers. All three chains have the same depth, so the MOSI
    // value that reaches the end of its chain lines up with the SCLK rise that
    // samples it.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;  // idle level: slave deselected
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    logic sclk_s;
    logic ss_s;
    logic mosi_s;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Edge detection on the synchronised signals
    // -------------------------------------------------------------------------
    logic sclk_prev;
    logic ss_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    logic sclk_rise;
    logic ss_fall;
    logic ss_rise;

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ss_fall   = ~ss_s & ss_prev;
    assign ss_rise   = ss_s & ~ss_prev;

    // -------------------------------------------------------------------------
    // Byte assembly. byte_stb pulses on the cycle after the 8th bit, while
    // shift_reg holds the complete byte. That byte stays stable for at least
    // 8 clk, which is the minimum time to the next SCLK rise.
    // -------------------------------------------------------------------------
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       byte_stb;
    logic       partial_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            byte_stb    <= 1'b0;
            partial_err <= 1'b0;
        end else begin
            byte_stb    <= 1'b0;
            partial_err <= 1'b0;
            if (ss_fall) begin
                bit_cnt <= '0;
            end else if (ss_rise) begin
                // A frame that ends mid-byte discards the bits gathered so far.
                if (bit_cnt != 3'd0) begin
                    partial_err <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (!ss_s && sclk_rise) begin
                shift_reg <= {shift_reg[6:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;  // wraps 7 -> 0 for back-to-back bytes
                if (bit_cnt == 3'd7) begin
                    byte_stb <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decoder: next-state and strobe decode for the current byte
    // -------------------------------------------------------------------------
    state_t state;
    state_t next_state;
    logic   emit_char;
    logic   emit_clear;
    logic   emit_seq;
    logic   byte_bad;

    // NOTE: every signal assigned here receives a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        emit_char  = 1'b0;
        emit_clear = 1'b0;
        emit_seq   = 1'b0;
        byte_bad   = 1'b0;
        if (byte_stb) begin
            if (shift_reg[7]) begin
                // A non-ASCII byte is dropped and the sequence state is left alone.
                byte_bad = 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (shift_reg == ESC_BYTE) begin
                            next_state = ST_ESC;
                        end else begin
                            emit_char = 1'b1;
                        end
                    end
                    ST_ESC: begin
                        if (shift_reg == CSI_BYTE) begin
                            next_state = ST_CSI;
                        end else if (shift_reg == ESC_BYTE) begin
                            emit_seq = 1'b1;  // a fresh ESC restarts the sequence
                        end else begin
                            emit_seq   = 1'b1;
                            emit_char  = 1'b1;
                            next_state = ST_IDLE;
                        end
                    end
                    ST_CSI: begin
                        if (shift_reg == CLEAR_BYTE) begin
                            emit_clear = 1'b1;
                            next_state = ST_IDLE;
                        end else if (shift_reg == ESC_BYTE) begin
                            emit_seq   = 1'b1;
                            next_state = ST_ESC;
                        end else begin
                            emit_seq   = 1'b1;
                            emit_char  = 1'b1;
                            next_state = ST_IDLE;
                        end
                    end
                    default: begin
                        next_state = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decoder state and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            char_data  <= '0;
            char_valid <= 1'b0;
            clear      <= 1'b0;
            frame_err  <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            state      <= next_state;
            char_valid <= emit_char;
            clear      <= emit_clear;
            seq_err    <= emit_seq;
            frame_err  <= byte_bad | partial_err;
            if (emit_char) begin
                char_data <= shift_reg[6:0];
            end
        end
    end

`ifdef LCD_RX_CURSOR_EN
    localparam int CURSOR_W = $clog2(COLS);
    localparam logic [CURSOR_W-1:0] CURSOR_LAST = CURSOR_W'(COLS - 1);

    // The cursor moves in the same cycle as the strobe it follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_pos <= '0;
        end else if (emit_clear) begin
            cursor_pos <= '0;
        end else if (emit_char) begin
            cursor_pos <= (cursor_pos == CURSOR_LAST) ? '0 : cursor_pos + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd_spi_rx
//   Self-checking bench for lcd_spi_rx. An SPI master task drives mode-0
//   frames. A monitor records every output strobe. A byte-level reference
//   model applies the stream rules (printable characters, ESC [ j clear,
//   sequence errors and frame errors) and builds the expected strobes. After
//   each step, the observed and expected records are compared.
// -----------------------------------------------------------------------------
module tb_lcd_spi_rx;

    localparam int COLS      = 16;
    localparam int CLK_HALF  = 5;    // 100 MHz system clock
    localparam int SCLK_HALF = 50;   // 10 MHz SCLK, 10x below clk
    localparam int SETTLE    = 30;   // clk cycles allowed for strobes to drain

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic [6:0] char_data;
    logic       char_valid;
    logic       clear;
    logic       frame_err;
    logic       seq_err;
`ifdef LCD_RX_CURSOR_EN
    logic [$clog2(COLS)-1:0] cursor_pos;
`endif

    lcd_spi_rx #(.SYNC_STAGES(2), .COLS(COLS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .char_data  (char_data),
        .char_valid (char_valid),
        .clear      (clear),
        .frame_err  (frame_err),
        .seq_err    (seq_err)
`ifdef LCD_RX_CURSOR_EN
        ,
        .cursor_pos (cursor_pos)
`endif
    );

    initial clk = 1'b0;
    always #CLK_HALF clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- observed strobes ----------------
    logic [6:0] obs_chars[$];
    int obs_clear, obs_fe, obs_se, obs_coinc, obs_both;

    always @(negedge clk) begin
        if (rst_n) begin
            if (char_valid) obs_chars.push_back(char_data);
            if (clear) obs_clear++;
            if (frame_err) obs_fe++;
            if (seq_err) obs_se++;
            if (seq_err && char_valid) obs_coinc++;
            if (char_valid && clear) obs_both++;
        end
    end

    // ---------------- reference model ----------------
    logic [6:0] exp_chars[$];
    int exp_clear, exp_fe, exp_se, exp_coinc;
    int m_state;       // 0: plain text, 1: after ESC, 2: after ESC [
    int m_cursor;
    logic [6:0] m_last_char;

    task automatic model_char(input logic [7:0] b);
        exp_chars.push_back(b[6:0]);
        m_last_char = b[6:0];
        m_cursor    = (m_cursor + 1) % COLS;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b[7]) begin
            exp_fe++;
        end else if (m_state == 0) begin
            if (b == 8'h1B) m_state = 1;
            else model_char(b);
        end else if (m_state == 1) begin
            if (b == 8'h5B) m_state = 2;
            else if (b == 8'h1B) exp_se++;
            else begin
                exp_se++; exp_coinc++; model_char(b); m_state = 0;
            end
        end else begin
            if (b == 8'h6A) begin
                exp_clear++; m_cursor = 0; m_state = 0;
            end else if (b == 8'h1B) begin
                exp_se++; m_state = 1;
            end else begin
                exp_se++; exp_coinc++; model_char(b); m_state = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_cursor    = 0;
        m_last_char = '0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_step(input string tag);
        int n;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        check({tag, ".n_char"}, obs_chars.size(), exp_chars.size());
        n = (obs_chars.size() < exp_chars.size()) ? obs_chars.size() : exp_chars.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.char%0d", tag, i), {25'd0, obs_chars[i]}, {25'd0, exp_chars[i]});
        check({tag, ".clear"}, obs_clear, exp_clear);
        check({tag, ".frame_err"}, obs_fe, exp_fe);
        check({tag, ".seq_err"}, obs_se, exp_se);
        check({tag, ".seq_with_char"}, obs_coinc, exp_coinc);
        check({tag, ".char_and_clear"}, obs_both, 0);
        check({tag, ".char_hold"}, {25'd0, char_data}, {25'd0, m_last_char});
`ifdef LCD_RX_CURSOR_EN
        check({tag, ".cursor"}, 32'(cursor_pos), m_cursor);
`endif
        obs_chars.delete(); exp_chars.delete();
        obs_clear = 0; obs_fe = 0; obs_se = 0; obs_coinc = 0; obs_both = 0;
        exp_clear = 0; exp_fe = 0; exp_se = 0; exp_coinc = 0;
    endtask

    // ---------------- SPI master ----------------
    task automatic frame_begin();
        ss_n = 1'b0;
        #SCLK_HALF;
    endtask

    task automatic frame_end();
        #SCLK_HALF;
        ss_n = 1'b1;
        #(4 * SCLK_HALF);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #SCLK_HALF;
            sclk = 1'b1;
            #SCLK_HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
        model_byte(b);
    endtask

    task automatic send_frame1(input logic [7:0] b);
        frame_begin();
        send_byte(b);
        frame_end();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.outputs", {27'd0, char_data, char_valid, clear, frame_err, seq_err}, 32'd0);
`ifdef LCD_RX_CURSOR_EN
        check("reset.cursor", 32'(cursor_pos), 32'd0);
`endif
        model_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1: return 8'h1B;
            2:    return 8'h5B;
            3:    return 8'h6A;
            4:    return 8'h80 | 8'($urandom_range(0, 127));
            default: return 8'(32 + $urandom_range(0, 94));
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; rst_n = 1'b1;
        model_reset();
        #2;
        do_reset();

        // 1: single printable character
        send_frame1(8'h41);
        compare_step("t1_char");

        // 2: clear sequence in one frame
        frame_begin();
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h6A);
        frame_end();
        compare_step("t2_clear_one_frame");

        // 3: clear sequence spread over three frames
        send_frame1(8'h1B); send_frame1(8'h5B); send_frame1(8'h6A);
        compare_step("t3_clear_split");

        // 4: broken sequence, then a plain character proves IDLE
        frame_begin();
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h42); send_byte(8'h43);
        frame_end();
        compare_step("t4_seq_err");

        // 5: partial byte, then a full frame
        frame_begin();
        send_bits(8'hA5, 5);
        frame_end();
        exp_fe++;
        send_frame1(8'h30);
        compare_step("t5_partial");

        // 6: byte with bit7 set
        send_frame1(8'hC1);
        compare_step("t6_bit7");

        // 7: reset mid-sequence
        frame_begin();
        send_byte(8'h1B); send_byte(8'h5B);
        frame_end();
        compare_step("t7_pre");
        do_reset();
        send_frame1(8'h6A);
        compare_step("t7_after_reset");

        // 8: cursor wrap, then clear
        frame_begin();
        for (int i = 0; i < 17; i++) send_byte(8'(8'h61 + (i % 26)));
        frame_end();
        compare_step("t8_17_chars");
        frame_begin();
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h6A);
        frame_end();
        compare_step("t8_clear");

        // ESC ESC [ j : repeated ESC flags seq_err and still completes the clear
        frame_begin();
        send_byte(8'h1B); send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h6A);
        frame_end();
        compare_step("esc_esc");

        // randomized stream
        for (int round = 0; round < 8; round++) begin
            int nframes;
            nframes = $urandom_range(1, 3);
            for (int f = 0; f < nframes; f++) begin
                int nbytes;
                nbytes = $urandom_range(1, 4);
                frame_begin();
                for (int k = 0; k < nbytes; k++) send_byte(rand_byte());
                if ($urandom_range(0, 4) == 0) begin
                    send_bits(8'h55, $urandom_range(1, 7));
                    exp_fe++;
                end
                frame_end();
            end
            compare_step($sformatf("rand%0d", round));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
